// File: rtl/sinc_pkg.sv
// Shared types and width-dependent constants for the signed increment counter.
package sinc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        HOLD  = 2'b10
    } sinc_state_t;

    // Largest positive two's-complement value for a w-bit word.
    function automatic longint max_pos(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Most negative two's-complement value for a w-bit word.
    function automatic longint min_neg(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/sinc_counter_sinc.sv
// Signed combinational incrementer: d = a + 1, wrapping in DATAWIDTH bits.
module SINC #(
    parameter int DATAWIDTH = 8
) (
    input  logic signed [DATAWIDTH-1:0] a,
    output logic signed [DATAWIDTH-1:0] d
);

    assign d = a + DATAWIDTH'(1);

endmodule

// File: rtl/sinc_counter.sv
// Signed up-counter from a loaded start value to an inclusive limit, with
// one-cycle done pulse and sticky overflow (wrap or saturate at max positive).
module sinc_counter
    import sinc_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int SATURATE  = 0
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        load,
    input  logic signed [DATAWIDTH-1:0] d_in,
    input  logic signed [DATAWIDTH-1:0] limit,
    input  logic                        en,
    output logic signed [DATAWIDTH-1:0] q,
    output logic                        at_limit,
    output logic                        done,
    output logic                        ovf
);

    localparam logic signed [DATAWIDTH-1:0] MAX_POS = DATAWIDTH'(max_pos(DATAWIDTH));
    localparam logic signed [DATAWIDTH-1:0] MIN_NEG = DATAWIDTH'(min_neg(DATAWIDTH));

    sinc_state_t                 state_q, state_d;
    logic signed [DATAWIDTH-1:0] count_q, count_d;
    logic signed [DATAWIDTH-1:0] count_inc;
    logic                        done_q, done_d;
    logic                        ovf_q, ovf_d;

    SINC #(.DATAWIDTH(DATAWIDTH)) u_sinc (
        .a (count_q),
        .d (count_inc)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;

        if (load) begin
            count_d = d_in;
            ovf_d   = 1'b0;
            state_d = COUNT;
        end else if (state_q == COUNT && en) begin
            // Terminal check wins over the overflow check when limit == MAX_POS.
            if (count_q == limit) begin
                done_d  = 1'b1;
                state_d = HOLD;
            end else if (count_q == MAX_POS) begin
                ovf_d = 1'b1;
                if (SATURATE != 0) begin
                    done_d  = 1'b1;
                    state_d = HOLD;
                end else begin
                    count_d = MIN_NEG;
                end
            end else begin
                count_d = count_inc;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign q        = count_q;
    assign done     = done_q;
    assign ovf      = ovf_q;
    assign at_limit = (count_q == limit) && (state_q != IDLE);

endmodule
